// File: rtl/tpsram_fifo_ctrl.sv
// Synchronous FIFO controller for a 64x8 two-port SRAM (write port B, read port A, common clock).
// Optional almost-full/almost-empty flags are built when FIFO_ALMOST_FLAGS_EN is defined.
module tpsram_fifo_ctrl #(
  parameter int AW            = 6,
  parameter int DW            = 8,
  parameter int AFULL_THRESH  = 56,
  parameter int AEMPTY_THRESH = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CLEAR,
  input  logic          PUSH,
  input  logic [DW-1:0] PUSH_DATA,
  input  logic          POP,
  output logic [DW-1:0] POP_DATA,
  output logic          POP_VALID,
  output logic          FULL,
  output logic          EMPTY,
  output logic [AW:0]   LEVEL,
  output logic          OVERFLOW,
  output logic          UNDERFLOW,
  output logic          AFULL,
  output logic          AEMPTY,
  output logic [DW-1:0] RAM_WD,
  output logic [AW-1:0] RAM_WADDR,
  output logic          RAM_WEN,
  output logic [AW-1:0] RAM_RADDR,
  output logic          RAM_REN,
  input  logic [DW-1:0] RAM_RD
);

  localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wptr_r;
  logic [AW:0] rptr_r;
  logic [AW:0] level_r;
  logic [AW:0] wptr_nxt_s;
  logic [AW:0] rptr_nxt_s;
  logic [AW:0] level_nxt_s;
  logic        full_r;
  logic        empty_r;
  logic        full_nxt_s;
  logic        empty_nxt_s;
  logic        pop_valid_r;
  logic        ovf_r;
  logic        unf_r;
  logic        ovf_nxt_s;
  logic        unf_nxt_s;
  logic        push_acc_s;
  logic        pop_acc_s;

  // Port acceptance; RESET and CLEAR keep both SRAM ports idle.
  always_comb begin
    push_acc_s = PUSH & ~full_r  & ~CLEAR & ~RESET;
    pop_acc_s  = POP  & ~empty_r & ~CLEAR & ~RESET;
  end

  // Next-state pointers, stickies and derived flags.
  always_comb begin
    wptr_nxt_s = wptr_r;
    rptr_nxt_s = rptr_r;
    ovf_nxt_s  = ovf_r;
    unf_nxt_s  = unf_r;
    if (CLEAR) begin
      wptr_nxt_s = PTR_ZERO;
      rptr_nxt_s = PTR_ZERO;
      ovf_nxt_s  = 1'b0;
      unf_nxt_s  = 1'b0;
    end else begin
      if (push_acc_s) begin
        wptr_nxt_s = wptr_r + PTR_ONE;
      end else begin
        wptr_nxt_s = wptr_r;
      end
      if (pop_acc_s) begin
        rptr_nxt_s = rptr_r + PTR_ONE;
      end else begin
        rptr_nxt_s = rptr_r;
      end
      ovf_nxt_s = ovf_r | (PUSH & full_r);
      unf_nxt_s = unf_r | (POP & empty_r);
    end
    // Wrap-bit pointer difference is the fill level, 0..2**AW.
    level_nxt_s = wptr_nxt_s - rptr_nxt_s;
    full_nxt_s  = (wptr_nxt_s[AW] != rptr_nxt_s[AW]) &&
                  (wptr_nxt_s[AW-1:0] == rptr_nxt_s[AW-1:0]);
    empty_nxt_s = (wptr_nxt_s == rptr_nxt_s);
  end

  // State registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wptr_r      <= PTR_ZERO;
      rptr_r      <= PTR_ZERO;
      level_r     <= PTR_ZERO;
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      pop_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
    end else begin
      wptr_r      <= wptr_nxt_s;
      rptr_r      <= rptr_nxt_s;
      level_r     <= level_nxt_s;
      full_r      <= full_nxt_s;
      empty_r     <= empty_nxt_s;
      pop_valid_r <= pop_acc_s;
      ovf_r       <= ovf_nxt_s;
      unf_r       <= unf_nxt_s;
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [AW:0] AFULL_LVL  = (AW+1)'(AFULL_THRESH);
  localparam logic [AW:0] AEMPTY_LVL = (AW+1)'(AEMPTY_THRESH);

  logic afull_r;
  logic aempty_r;

  // Almost flags track the same next level that LEVEL loads.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
    end else begin
      afull_r  <= (level_nxt_s >= AFULL_LVL);
      aempty_r <= (level_nxt_s <= AEMPTY_LVL);
    end
  end

  assign AFULL  = afull_r;
  assign AEMPTY = aempty_r;
`else
  assign AFULL  = 1'b0;
  assign AEMPTY = 1'b1;
`endif

  assign RAM_WEN   = push_acc_s;
  assign RAM_WADDR = wptr_r[AW-1:0];
  assign RAM_WD    = PUSH_DATA;
  assign RAM_REN   = pop_acc_s;
  assign RAM_RADDR = rptr_r[AW-1:0];
  assign POP_DATA  = RAM_RD;
  assign POP_VALID = pop_valid_r;
  assign FULL      = full_r;
  assign EMPTY     = empty_r;
  assign LEVEL     = level_r;
  assign OVERFLOW  = ovf_r;
  assign UNDERFLOW = unf_r;

endmodule

// File: tb/tb_tpsram_fifo_ctrl.sv
// Scoreboard bench for tpsram_fifo_ctrl with a behavioural 64x8 two-port SRAM attached.
module tb_tpsram_fifo_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CLEAR = 1'b0;
  logic       PUSH = 1'b0;
  logic [7:0] PUSH_DATA = 8'h00;
  logic       POP = 1'b0;
  logic [7:0] POP_DATA;
  logic       POP_VALID;
  logic       FULL;
  logic       EMPTY;
  logic [6:0] LEVEL;
  logic       OVERFLOW;
  logic       UNDERFLOW;
  logic       AFULL;
  logic       AEMPTY;
  logic [7:0] RAM_WD;
  logic [5:0] RAM_WADDR;
  logic       RAM_WEN;
  logic [5:0] RAM_RADDR;
  logic       RAM_REN;
  logic [7:0] RAM_RD = 8'h00;

  logic [7:0] mem [64];

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_q   [$];
  logic [7:0] exp_q [$];
  int         m_level = 0;
  logic [6:0] m_w = 7'd0;
  logic [6:0] m_r = 7'd0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       m_valid = 1'b0;

  tpsram_fifo_ctrl dut (
    .CLK(CLK), .RESET(RESET), .CLEAR(CLEAR), .PUSH(PUSH), .PUSH_DATA(PUSH_DATA),
    .POP(POP), .POP_DATA(POP_DATA), .POP_VALID(POP_VALID), .FULL(FULL), .EMPTY(EMPTY),
    .LEVEL(LEVEL), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .AFULL(AFULL), .AEMPTY(AEMPTY),
    .RAM_WD(RAM_WD), .RAM_WADDR(RAM_WADDR), .RAM_WEN(RAM_WEN), .RAM_RADDR(RAM_RADDR),
    .RAM_REN(RAM_REN), .RAM_RD(RAM_RD)
  );

  always #5 CLK = ~CLK;

  // SRAM macro: synchronous write, 1-cycle synchronous read.
  always @(posedge CLK) begin
    if (RAM_WEN === 1'b1) mem[RAM_WADDR] <= RAM_WD;
    if (RAM_REN === 1'b1) RAM_RD <= mem[RAM_RADDR];
  end

  // Monitor: every POP_VALID beat must match the next expected byte.
  always @(negedge CLK) begin
    if (POP_VALID === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_data: POP_VALID=1 with nothing expected, got %02h", POP_DATA);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (POP_DATA !== e) begin
          n_err++;
          $display("FAIL pop_data: got %02h expected %02h", POP_DATA, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_level = 0;
    m_w = 7'd0;
    m_r = 7'd0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic chk_state();
    chk("level", 32'(LEVEL), 32'(m_level));
    chk("full", 32'(FULL), 32'(m_level == 64));
    chk("empty", 32'(EMPTY), 32'(m_level == 0));
    chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
    chk("underflow", 32'(UNDERFLOW), 32'(m_unf));
    chk("pop_valid", 32'(POP_VALID), 32'(m_valid));
`ifdef FIFO_ALMOST_FLAGS_EN
    chk("afull", 32'(AFULL), 32'(m_level >= 56));
    chk("aempty", 32'(AEMPTY), 32'(m_level <= 8));
`else
    chk("afull", 32'(AFULL), 32'd0);
    chk("aempty", 32'(AEMPTY), 32'd1);
`endif
  endtask

  // One clock cycle: drive, check pre-edge outputs, clock, update model.
  task automatic cycle(input logic push, input logic [7:0] d, input logic pop, input logic clr);
    logic push_ok;
    logic pop_ok;
    PUSH = push; PUSH_DATA = d; POP = pop; CLEAR = clr;
    push_ok = push && !clr && (m_level != 64);
    pop_ok  = pop && !clr && (m_level != 0);
    #2;
    chk_state();
    chk("ram_wen", 32'(RAM_WEN), 32'(push_ok));
    chk("ram_ren", 32'(RAM_REN), 32'(pop_ok));
    if (push_ok) begin
      chk("ram_waddr", 32'(RAM_WADDR), 32'(m_w[5:0]));
      chk("ram_wd", 32'(RAM_WD), 32'(d));
    end
    if (pop_ok) chk("ram_raddr", 32'(RAM_RADDR), 32'(m_r[5:0]));
    @(posedge CLK);
    #1;
    if (clr) begin
      m_q.delete();
      m_level = 0; m_w = 7'd0; m_r = 7'd0;
      m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (push && m_level == 64) m_ovf = 1'b1;
      if (pop && m_level == 0) m_unf = 1'b1;
      if (pop_ok) begin
        exp_q.push_back(m_q.pop_front());
        m_r = m_r + 7'd1;
      end
      if (push_ok) begin
        m_q.push_back(d);
        m_w = m_w + 7'd1;
      end
      m_level = m_q.size();
    end
    m_valid = pop_ok;
    PUSH = 1'b0; POP = 1'b0; CLEAR = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held across two edges, then idle checks.
    repeat (2) @(posedge CLK);
    #1;
    chk_state();
    chk("ram_wen_rst", 32'(RAM_WEN), 32'd0);
    RESET = 1'b0;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill 0x00..0x3F, then a rejected push of 0xAA.
    for (int i = 0; i < 64; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    // Drain 64 bytes, then an extra pop.
    for (int i = 0; i < 64; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Push+pop while empty, refill, push+pop while full.
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    for (int i = 0; i < 63; i++) cycle(1'b1, 8'(8'h80 + 8'(i)), 1'b0, 1'b0);
    cycle(1'b1, 8'hC3, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Wrap across address 63 -> 0.
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h10 + 8'(i)), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'hA0 + 8'(i)), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // CLEAR in the cycle after a pop.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h70 + 8'(i)), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Async RESET in the middle of a streaming burst.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h20 + 8'(i)), 1'b0, 1'b0);
    cycle(1'b1, 8'h30, 1'b1, 1'b0);
    PUSH = 1'b1; PUSH_DATA = 8'h31; POP = 1'b1;
    #1;
    RESET = 1'b1;
    model_reset();
    #1;
    chk_state();
    chk("ram_wen_rst", 32'(RAM_WEN), 32'd0);
    chk("ram_ren_rst", 32'(RAM_REN), 32'd0);
    @(posedge CLK);
    #1;
    PUSH = 1'b0; POP = 1'b0;
    RESET = 1'b0;
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
